dcw_decode: RTL and testbench
=============================

DCW_DECODE -- requirements
Module: dcw_decode

Interface
REQ-001 Parameter: DTC_L, default 12, DTC control word width; the thermometer part is fixed at 7 bits and the binary part at DTC_L-3 bits.
REQ-002 Port: REFDTC  input  1  DTC reference clock; all state updates occur on the posedge, giving half-period margin to the negedge-launched sampler outputs.
REQ-003 Port: sync_nrst  input  1  reset, asynchronous, active-low.
REQ-004 Port: LOOP_TEMP_CODE  input  7  thermometer MSB code from the DCW sampler.
REQ-005 Port: LOOP_BINARY_OUT  input  9  binary LSB code from the DCW sampler.
REQ-006 Port: DCWREF  input  DTC_L  expected DCW (sampler test output), aligned with the codes.
REQ-007 Port: CHK_EN  input  1  level enable for the check window.
REQ-008 Port: CHK_LEN  input  8  number of samples in the check window.
REQ-009 Port: DCWDEC  output  DTC_L  reconstructed DCW.
REQ-010 Port: DEC_VLD  output  1  DCWDEC holds a decoded sample.
REQ-011 Port: BUBBLE_ERR  output  1  thermometer code of the current DCWDEC sample was non-canonical.
REQ-012 Port: MISMATCH  output  1  DCWDEC differs from the aligned DCWREF.
REQ-013 Port: ERR_CNT  output  8  window error count, saturating.
REQ-014 Port: CHK_BUSY / CHK_DONE  output  1 each  window running / window complete.

Function
REQ-015 Stage 1 shall register LOOP_TEMP_CODE, LOOP_BINARY_OUT and DCWREF on every posedge.
REQ-016 Decode: canonical codes 0000000, 0000001, 0000011, ..., 1111111 map to 0..7; any other code maps to its popcount (number of ones) with bubble=1.
REQ-017 Stage 2 shall register DCWDEC={msb3,bin9}, BUBBLE_ERR, and MISMATCH=(DCWDEC!=stage-1 DCWREF); latency from input to DCWDEC is 2 posedges.
REQ-018 DEC_VLD shall be 0 at reset, 0 after the first posedge, and 1 from the second posedge onward.
REQ-019 MISMATCH and BUBBLE_ERR shall be forced to 0 while DEC_VLD=0.
REQ-020 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-021 IDLE->RUN when CHK_EN=1 and CHK_LEN!=0; on entry, clear ERR_CNT and the sample counter, and latch CHK_LEN.
REQ-022 IDLE shall hold while CHK_LEN=0, regardless of CHK_EN.
REQ-023 In RUN, each posedge with DEC_VLD=1 shall increment the sample counter.
REQ-024 In RUN, when (MISMATCH|BUBBLE_ERR)=1 on a counted sample, ERR_CNT shall increment, saturating at 255.
REQ-025 RUN->DONE on the posedge at which the sample counter reaches the latched length; that last sample is counted.
REQ-026 RUN->IDLE (abort) when CHK_EN=0; ERR_CNT is held and CHK_DONE is not asserted.
REQ-027 DONE->IDLE when CHK_EN=0; ERR_CNT is held in DONE and IDLE until the next RUN entry.
REQ-028 CHK_BUSY=1 exactly in RUN; CHK_DONE=1 exactly in DONE.
REQ-029 CHK_LEN changes during RUN shall have no effect.

Reset
REQ-030 Asserting sync_nrst shall asynchronously clear all pipeline registers, DCWDEC, DEC_VLD, BUBBLE_ERR, MISMATCH, ERR_CNT, CHK_BUSY, CHK_DONE and the sample counter to 0, and set the FSM to IDLE.
REQ-031 Reset asserted mid-window shall abort the window with no CHK_DONE pulse.
REQ-032 After reset deassertion, the pipeline warm-up of REQ-018 shall restart.

Verification
REQ-033 Temp=0000111, bin=0x1A5, DCWREF=0x7A5 -> after 2 posedges DCWDEC=0x7A5, MISMATCH=0, BUBBLE_ERR=0.
REQ-034 Temp=0010111 -> msb3=4, BUBBLE_ERR=1 for one sample; in RUN, ERR_CNT increments by 1.
REQ-035 CHK_LEN=4, CHK_EN=1, DCWREF offset by 1 on samples 2 and 3 -> CHK_DONE after 4 counted samples, ERR_CNT=2.
REQ-036 CHK_LEN=255 with every sample mismatched plus 10 further samples -> ERR_CNT holds at 255, never wraps.
REQ-037 CHK_EN dropped after 2 of 8 samples -> FSM returns to IDLE, CHK_DONE stays 0, ERR_CNT is held; CHK_LEN=0 with CHK_EN=1 -> FSM stays in IDLE.
REQ-038 sync_nrst asserted in RUN -> all outputs 0 immediately; DEC_VLD returns to 1 on the second posedge after release.

Source files
------------

// File: rtl/dcw_decode.sv
// dcw_decode: rebuilds the DTC control word from the sampler's thermometer/binary
// split, flags bubbles and reference mismatches, and counts errors over a check window.
module dcw_decode #(
  parameter int DTC_L = 12
) (
  input  logic             REFDTC,
  input  logic             sync_nrst,
  input  logic [6:0]       LOOP_TEMP_CODE,
  input  logic [DTC_L-4:0] LOOP_BINARY_OUT,
  input  logic [DTC_L-1:0] DCWREF,
  input  logic             CHK_EN,
  input  logic [7:0]       CHK_LEN,
  output logic [DTC_L-1:0] DCWDEC,
  output logic             DEC_VLD,
  output logic             BUBBLE_ERR,
  output logic             MISMATCH,
  output logic [7:0]       ERR_CNT,
  output logic             CHK_BUSY,
  output logic             CHK_DONE
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [6:0]       r_tempS1;
  logic [DTC_L-4:0] r_binS1;
  logic [DTC_L-1:0] r_refS1;
  logic             r_vldS1;

  logic [DTC_L-1:0] r_dcwDec;
  logic             r_decVld;
  logic             r_bubble;
  logic             r_mismatch;

  logic [1:0]       r_state;
  logic [7:0]       r_sampCnt;
  logic [7:0]       r_len;
  logic [7:0]       r_errCnt;

  logic [2:0]       w_msb3;
  logic [7:0]       w_tempPlus1;
  logic             w_bubble;
  logic [DTC_L-1:0] w_dcw;
  logic [7:0]       w_cntNext;

  always_ff @(posedge REFDTC or negedge sync_nrst) begin
    if (!sync_nrst) begin
      r_tempS1 <= '0;
      r_binS1  <= '0;
      r_refS1  <= '0;
      r_vldS1  <= 1'b0;
    end else begin
      r_tempS1 <= LOOP_TEMP_CODE;
      r_binS1  <= LOOP_BINARY_OUT;
      r_refS1  <= DCWREF;
      r_vldS1  <= 1'b1;
    end
  end

  // The MSB value is always the popcount; a canonical code is a run of ones from bit 0,
  // so adding one clears every set bit and the AND with the original is zero.
  always_comb begin
    w_msb3 = '0;
    for (int i = 0; i < 7; i++) begin
      w_msb3 = w_msb3 + {2'b00, r_tempS1[i]};
    end
  end

  assign w_tempPlus1 = {1'b0, r_tempS1} + 8'd1;
  assign w_bubble    = |({1'b0, r_tempS1} & w_tempPlus1);
  assign w_dcw       = {w_msb3, r_binS1};

  always_ff @(posedge REFDTC or negedge sync_nrst) begin
    if (!sync_nrst) begin
      r_dcwDec   <= '0;
      r_decVld   <= 1'b0;
      r_bubble   <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_dcwDec   <= w_dcw;
      r_decVld   <= r_vldS1;
      r_bubble   <= r_vldS1 & w_bubble;
      r_mismatch <= r_vldS1 & (w_dcw != r_refS1);
    end
  end

  assign w_cntNext = r_sampCnt + 8'd1;

  // Counting uses the flags already on the outputs, so each registered sample is judged once.
  always_ff @(posedge REFDTC or negedge sync_nrst) begin
    if (!sync_nrst) begin
      r_state   <= IDLE;
      r_sampCnt <= '0;
      r_len     <= '0;
      r_errCnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (CHK_EN && (CHK_LEN != 8'd0)) begin
            r_state   <= RUN;
            r_errCnt  <= '0;
            r_sampCnt <= '0;
            r_len     <= CHK_LEN;
          end
        end
        RUN: begin
          if (!CHK_EN) begin
            r_state <= IDLE;
          end else if (r_decVld) begin
            r_sampCnt <= w_cntNext;
            if ((r_mismatch || r_bubble) && (r_errCnt != 8'hFF)) begin
              r_errCnt <= r_errCnt + 8'd1;
            end
            if (w_cntNext == r_len) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (!CHK_EN) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DCWDEC     = r_dcwDec;
  assign DEC_VLD    = r_decVld;
  assign BUBBLE_ERR = r_bubble;
  assign MISMATCH   = r_mismatch;
  assign ERR_CNT    = r_errCnt;
  assign CHK_BUSY   = (r_state == RUN);
  assign CHK_DONE   = (r_state == DONE);

endmodule

// File: tb/tb_dcw_decode.sv
// tb_dcw_decode: table vectors, directed window sequences and random traffic,
// all compared against a sample-history reference model.
module tb_dcw_decode;

  localparam int DTC_L = 12;
  localparam int BIN_W = DTC_L - 3;

  logic             REFDTC = 1'b0;
  logic             sync_nrst;
  logic [6:0]       LOOP_TEMP_CODE;
  logic [BIN_W-1:0] LOOP_BINARY_OUT;
  logic [DTC_L-1:0] DCWREF;
  logic             CHK_EN;
  logic [7:0]       CHK_LEN;
  logic [DTC_L-1:0] DCWDEC;
  logic             DEC_VLD;
  logic             BUBBLE_ERR;
  logic             MISMATCH;
  logic [7:0]       ERR_CNT;
  logic             CHK_BUSY;
  logic             CHK_DONE;

  int nChecks = 0;
  int nFails  = 0;

  dcw_decode #(.DTC_L(DTC_L)) dut (
    .REFDTC          (REFDTC),
    .sync_nrst       (sync_nrst),
    .LOOP_TEMP_CODE  (LOOP_TEMP_CODE),
    .LOOP_BINARY_OUT (LOOP_BINARY_OUT),
    .DCWREF          (DCWREF),
    .CHK_EN          (CHK_EN),
    .CHK_LEN         (CHK_LEN),
    .DCWDEC          (DCWDEC),
    .DEC_VLD         (DEC_VLD),
    .BUBBLE_ERR      (BUBBLE_ERR),
    .MISMATCH        (MISMATCH),
    .ERR_CNT         (ERR_CNT),
    .CHK_BUSY        (CHK_BUSY),
    .CHK_DONE        (CHK_DONE)
  );

  always #5 REFDTC = ~REFDTC;

  typedef struct {
    logic [6:0]       temp;
    logic [BIN_W-1:0] bin;
    logic [DTC_L-1:0] dref;
    logic [DTC_L-1:0] expDec;
    logic             expBub;
    logic             expMis;
  } vec_t;

  typedef struct {
    logic [6:0]       temp;
    logic [BIN_W-1:0] bin;
    logic [DTC_L-1:0] dref;
  } samp_t;

  // Reference model: history of applied samples plus window bookkeeping (0 idle, 1 run, 2 done).
  samp_t hist[$];
  int    edges;
  int    mDec, mErr, mCnt, mLen, mMode;
  bit    mVld, mBub, mMis;

  function automatic int popc(input logic [6:0] t);
    int n = 0;
    for (int i = 0; i < 7; i++) if (t[i]) n++;
    return n;
  endfunction

  task automatic modelReset();
    hist.delete();
    edges = 0;
    mDec = 0; mErr = 0; mCnt = 0; mLen = 0; mMode = 0;
    mVld = 0; mBub = 0; mMis = 0;
  endtask

  task automatic modelClock();
    samp_t s;
    int ones;
    case (mMode)
      0: if (CHK_EN && CHK_LEN != 0) begin mMode = 1; mErr = 0; mCnt = 0; mLen = int'(CHK_LEN); end
      1: begin
        if (!CHK_EN) mMode = 0;
        else if (mVld) begin
          mCnt++;
          if ((mMis || mBub) && mErr < 255) mErr++;
          if (mCnt == mLen) mMode = 2;
        end
      end
      default: if (!CHK_EN) mMode = 0;
    endcase
    edges++;
    if (hist.size() > 0) begin
      s    = hist[$];
      ones = popc(s.temp);
      mDec = ones * (1 << BIN_W) + int'(s.bin);
      mBub = (edges >= 2) && (int'(s.temp) != (1 << ones) - 1);
      mMis = (edges >= 2) && (mDec != int'(s.dref));
    end else begin
      mDec = 0; mBub = 0; mMis = 0;
    end
    mVld = (edges >= 2);
    s.temp = LOOP_TEMP_CODE;
    s.bin  = LOOP_BINARY_OUT;
    s.dref = DCWREF;
    hist.push_back(s);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    check("DCWDEC",     32'(DCWDEC),     32'(mDec));
    check("DEC_VLD",    32'(DEC_VLD),    32'(mVld));
    check("BUBBLE_ERR", 32'(BUBBLE_ERR), 32'(mBub));
    check("MISMATCH",   32'(MISMATCH),   32'(mMis));
    check("ERR_CNT",    32'(ERR_CNT),    32'(mErr));
    check("CHK_BUSY",   32'(CHK_BUSY),   32'(mMode == 1));
    check("CHK_DONE",   32'(CHK_DONE),   32'(mMode == 2));
  endtask

  task automatic applyStimulus(input logic [6:0] t, input logic [BIN_W-1:0] b,
                               input logic [DTC_L-1:0] r, input logic en, input logic [7:0] len);
    LOOP_TEMP_CODE  = t;
    LOOP_BINARY_OUT = b;
    DCWREF          = r;
    CHK_EN          = en;
    CHK_LEN         = len;
    @(posedge REFDTC);
    modelClock();
    @(negedge REFDTC);
    checkOutput();
  endtask

  task automatic applySample(input int msb, input int bin, input int refOff,
                             input logic en, input int len);
    logic [6:0]       t;
    logic [BIN_W-1:0] b;
    logic [DTC_L-1:0] r;
    t = 7'((1 << msb) - 1);
    b = BIN_W'(bin);
    r = DTC_L'((msb << BIN_W) + int'(b) + refOff);
    applyStimulus(t, b, r, en, 8'(len));
  endtask

  vec_t             vt[6];
  logic [6:0]       rt;
  logic [BIN_W-1:0] rb;
  logic [DTC_L-1:0] rr;
  logic             ren;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vt[0] = '{temp: 7'b0000111, bin: 9'h1A5, dref: 12'h7A5, expDec: 12'h7A5, expBub: 1'b0, expMis: 1'b0};
    vt[1] = '{temp: 7'b0010111, bin: 9'h000, dref: 12'h800, expDec: 12'h800, expBub: 1'b1, expMis: 1'b0};
    vt[2] = '{temp: 7'b1111111, bin: 9'h1FF, dref: 12'hFFF, expDec: 12'hFFF, expBub: 1'b0, expMis: 1'b0};
    vt[3] = '{temp: 7'b0000000, bin: 9'h000, dref: 12'h001, expDec: 12'h000, expBub: 1'b0, expMis: 1'b1};
    vt[4] = '{temp: 7'b1000000, bin: 9'h055, dref: 12'h255, expDec: 12'h255, expBub: 1'b1, expMis: 1'b0};
    vt[5] = '{temp: 7'b0111111, bin: 9'h100, dref: 12'hD00, expDec: 12'hD00, expBub: 1'b0, expMis: 1'b0};

    sync_nrst = 1'b0;
    LOOP_TEMP_CODE = '0; LOOP_BINARY_OUT = '0; DCWREF = '0;
    CHK_EN = 1'b0; CHK_LEN = '0;
    modelReset();
    #2;
    checkOutput();
    #5 sync_nrst = 1'b1;
    @(negedge REFDTC);

    // Warm-up: valid only from the second edge after release.
    applySample(3, 7, 0, 1'b0, 0);
    check("warmup_vld1", 32'(DEC_VLD), 32'd0);
    applySample(3, 7, 0, 1'b0, 0);
    check("warmup_vld2", 32'(DEC_VLD), 32'd1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vt[i].temp, vt[i].bin, vt[i].dref, 1'b0, 8'd0);
      applyStimulus(vt[i].temp, vt[i].bin, vt[i].dref, 1'b0, 8'd0);
      check("tbl_dec", 32'(DCWDEC),     32'(vt[i].expDec));
      check("tbl_bub", 32'(BUBBLE_ERR), 32'(vt[i].expBub));
      check("tbl_mis", 32'(MISMATCH),   32'(vt[i].expMis));
    end
    applySample(2, 3, 0, 1'b0, 0);

    // Single bubble inside a 3-sample window.
    applySample(1, 1, 0, 1'b1, 3);
    applyStimulus(7'b0010111, 9'h000, 12'h800, 1'b1, 8'd3);
    applySample(2, 2, 0, 1'b1, 3);
    applySample(2, 3, 0, 1'b1, 3);
    check("bubble_done", 32'(CHK_DONE), 32'd1);
    check("bubble_err",  32'(ERR_CNT),  32'd1);
    applySample(2, 4, 0, 1'b0, 0);

    // Length 4 with reference offsets on samples 2 and 3.
    for (int i = 0; i < 5; i++) applySample(i + 1, 10 * i, (i <= 1) ? 1 : 0, 1'b1, 4);
    check("len4_done", 32'(CHK_DONE), 32'd1);
    check("len4_err",  32'(ERR_CNT),  32'd2);
    applySample(5, 1, 1, 1'b1, 4);
    applySample(5, 1, 1, 1'b1, 4);
    applySample(5, 1, 0, 1'b0, 4);
    check("len4_held", 32'(ERR_CNT), 32'd2);

    // Full-length window, every sample wrong, then extra samples.
    applySample(0, 0, 5, 1'b0, 0);
    for (int i = 0; i < 265; i++) applySample(i % 8, i, 5, 1'b1, 255);
    check("sat_err",  32'(ERR_CNT),  32'd255);
    check("sat_done", 32'(CHK_DONE), 32'd1);
    applySample(1, 0, 0, 1'b0, 0);

    // Abort after 2 of 8 samples, then a zero length must not start a window.
    applySample(2, 9, 3, 1'b1, 8);
    applySample(2, 9, 0, 1'b1, 8);
    applySample(2, 9, 0, 1'b1, 8);
    applySample(2, 9, 0, 1'b0, 8);
    check("abort_busy", 32'(CHK_BUSY), 32'd0);
    check("abort_done", 32'(CHK_DONE), 32'd0);
    check("abort_err",  32'(ERR_CNT),  32'd1);
    for (int i = 0; i < 4; i++) begin
      applySample(4, i, 1, 1'b1, 0);
      check("len0_busy", 32'(CHK_BUSY), 32'd0);
    end

    // Asynchronous reset in the middle of a window.
    applySample(3, 3, 1, 1'b1, 20);
    for (int i = 0; i < 4; i++) applySample(3, 3, 1, 1'b1, 20);
    #2 sync_nrst = 1'b0;
    #1 modelReset();
    checkOutput();
    check("rst_busy", 32'(CHK_BUSY), 32'd0);
    CHK_EN = 1'b0;
    @(negedge REFDTC);
    check("rst_hold_done", 32'(CHK_DONE), 32'd0);
    sync_nrst = 1'b1;
    applySample(6, 6, 0, 1'b0, 0);
    check("rst_vld1", 32'(DEC_VLD), 32'd0);
    applySample(6, 6, 0, 1'b0, 0);
    check("rst_vld2", 32'(DEC_VLD), 32'd1);

    // Random traffic with enable toggles and length changes mid-window.
    ren = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rt = 7'($urandom());
      else rt = 7'((1 << $urandom_range(0, 7)) - 1);
      rb = BIN_W'($urandom());
      if ($urandom_range(0, 2) == 0) rr = DTC_L'($urandom());
      else rr = DTC_L'((popc(rt) << BIN_W) + int'(rb));
      if ($urandom_range(0, 19) == 0) ren = ~ren;
      applyStimulus(rt, rb, rr, ren, 8'($urandom_range(0, 12)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
